nonce_result_serializer: RTL

- Sits directly downstream of nonce_decoder and consumes its valid_o / success_o / nonce_o result stream.
- Buffers search results in a small FIFO.
- Serializes each result into a byte-wide frame with a valid/ready handshake toward the host output link.
- Flushes results still queued for a stale block when a new block header is broadcast.

---
 rtl/nonce_result_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/nonce_result_serializer.sv
// Queues nonce_decoder results and streams each one to the host as a byte frame:
// success = tag + 4 nonce bytes (MSB first), failure = tag only.
module nonce_result_serializer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [7:0]  SUCCESS_TAG = 8'h01,
  parameter logic [7:0]  FAIL_TAG    = 8'h00
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic                          success_i,
  input  logic [31:0]                   nonce_i,
  input  logic                          newblock_i,
  input  logic                          out_ready_i,
  output logic                          out_valid_o,
  output logic [7:0]                    out_data_o,
  output logic                          out_last_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [32:0]       mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, waddr;
  logic [CntW-1:0]   count_q, count_d;
  logic [32:0]       frame_q;
  logic [2:0]        idx_q;
  logic              overflow_q;
  logic              full, empty, push, pop, xfer, frame_last;

  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  // Flush outranks the idle pop so a stale result never starts a frame.
  assign pop   = (state_q == StIdle) && !empty && !newblock_i;
  assign push  = valid_i && (newblock_i || !full || pop);
  assign xfer  = (state_q == StSend) && out_ready_i;
  assign frame_last = frame_q[32] ? (idx_q == 3'd4) : 1'b1;
  assign waddr = newblock_i ? '0 : wr_ptr_q;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (pop) state_d = StSend;
      StSend: if (xfer && frame_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[waddr] <= {success_i, nonce_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (newblock_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= push ? PtrW'(1) : '0;
        count_q  <= push ? CntW'(1) : '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_d;
      end
      if (valid_i && !push) overflow_q <= 1'b1;
      if (pop) begin
        frame_q <= mem[rd_ptr_q];
        idx_q   <= '0;
      end else if (xfer && !frame_last) begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  always_comb begin
    out_data_o = 8'h00;
    if (state_q == StSend) begin
      case (idx_q)
        3'd0:    out_data_o = frame_q[32] ? SUCCESS_TAG : FAIL_TAG;
        3'd1:    out_data_o = frame_q[31:24];
        3'd2:    out_data_o = frame_q[23:16];
        3'd3:    out_data_o = frame_q[15:8];
        3'd4:    out_data_o = frame_q[7:0];
        default: out_data_o = 8'h00;
      endcase
    end
  end

  assign out_valid_o  = (state_q == StSend);
  assign out_last_o   = (state_q == StSend) && frame_last;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule
